state_unloader: RTL

STATE_UNLOADER -- requirements
Module: state_unloader

---
 rtl/state_unloader_pkg.sv | 24 ++
 rtl/state_unloader_lane_counter.sv | 26 ++
 rtl/state_unloader.sv | 77 +++++++
 3 files changed

// File: rtl/state_unloader_pkg.sv
// Shared state-file definitions: lane geometry, unloader FSM encoding and count clamping.
// Used by the unloader and the encoder datapath so both agree on lane order and sizes.
package state_unloader_pkg;

    localparam int PKG_LANE_W = 64;
    localparam int PKG_LANES  = 25;
    localparam int CNT_W      = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SEND  = 3'd3,
        ST_DONE  = 3'd4
    } unl_state_t;

    // A request of 0 or beyond the file size means "the whole file".
    function automatic logic [CNT_W-1:0] clamp_lanes(input logic [CNT_W-1:0] req, input int lanes);
        if (req == '0 || 32'(req) > lanes)
            return CNT_W'(lanes);
        return req;
    endfunction

endpackage

// File: rtl/state_unloader_lane_counter.sv
// Lane index counter: clears to 0, steps by one on enable, flags count == limit-1.
// Zero latency on the flag; no backpressure of its own (enable is the caller's handshake).
module lane_counter
    import state_unloader_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= count + CNT_W'(1);
    end

    assign terminal = (count == limit - CNT_W'(1));

endmodule

// File: rtl/state_unloader.sv
// Streams lanes 0..N-1 of the state file out as beats: 3 cycles per lane (read, capture, send).
// A stalled beat holds data/last/address steady and no further read is issued until it is taken.
module state_unloader
    import state_unloader_pkg::*;
#(
    parameter int LANE_W = PKG_LANE_W,
    parameter int LANES  = PKG_LANES
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [4:0]        out_lanes,
    output logic [4:0]        mem_addr,
    output logic              mem_rd,
    input  logic [LANE_W-1:0] mem_rdata,
    output logic [LANE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    unl_state_t       state, state_nxt;
    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] lane_idx;
    logic             lane_term;
    logic             accept;
    logic             beat_take;

    assign accept    = (state == ST_IDLE) && start;
    assign beat_take = (state == ST_SEND) && out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            n_q      <= '0;
            out_data <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                n_q <= clamp_lanes(out_lanes, LANES);
            if (state == ST_LOAD)
                out_data <= mem_rdata;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_FETCH;
            ST_FETCH: state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_SEND;
            ST_SEND:  if (out_ready) state_nxt = lane_term ? ST_DONE : ST_FETCH;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    lane_counter u_lane_counter (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (accept),
        .enable   (beat_take && !lane_term),
        .limit    (n_q),
        .count    (lane_idx),
        .terminal (lane_term)
    );

    assign mem_addr  = lane_idx;
    assign mem_rd    = (state == ST_FETCH);
    assign out_valid = (state == ST_SEND);
    assign out_last  = (state == ST_SEND) && lane_term;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

endmodule
